// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative multiply/divide unit with a start/busy/ready handshake.
// Multiply uses radix-2 Booth recoding (one step per cycle). Divide uses restoring
// division on operand magnitudes, followed by a sign-fixup cycle.
// Optional feature macro: MULTDIV_UNSIGNED_EN adds the is_unsigned port and an
// unsigned mode. Without it, every operation is signed.
module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             kill,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] result,
  output logic             exception
);

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL1_W   = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  // Multiply: upper accumulator (two guard bits so an unsigned multiplicand
  // cannot overflow the add/subtract). Divide: remainder in the low WIDTH bits.
  logic [WIDTH+1:0]   hi_r;
  // Multiply: multiplier being shifted out. Divide: dividend in, quotient out.
  logic [WIDTH-1:0]   lo_r;
  logic               qm1_r;
  logic [WIDTH+1:0]   mcand_r;
  logic [WIDTH-1:0]   dvsr_r;
  logic               bmsb_r;
  logic               is_mul_r;
  logic               sgn_r;
  logic               neg_r;
  logic               exc_r;

  logic               start_sgn_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic               start_ovf_s;
  logic [WIDTH+1:0]   booth_sum_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic [2*WIDTH-1:0] mul_corr_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic               mul_exc_s;

`ifdef MULTDIV_UNSIGNED_EN
  assign start_sgn_s = ~is_unsigned;
`else
  assign start_sgn_s = 1'b1;
`endif

  // Operand preparation on the start edge: magnitudes for the divider and
  // detection of the signed MIN / -1 overflow case.
  assign a_neg_s     = start_sgn_s & operand_a[WIDTH-1];
  assign b_neg_s     = start_sgn_s & operand_b[WIDTH-1];
  assign a_mag_s     = a_neg_s ? (~operand_a + ONE_W) : operand_a;
  assign b_mag_s     = b_neg_s ? (~operand_b + ONE_W) : operand_b;
  assign start_ovf_s = start_sgn_s & (operand_a == MIN_W) & (operand_b == ALL1_W);

  // Booth recoding of the current multiplier bit pair selects add, subtract or hold.
  always_comb begin
    booth_sum_s = hi_r;
    case ({lo_r[0], qm1_r})
      2'b01:   booth_sum_s = hi_r + mcand_r;
      2'b10:   booth_sum_s = hi_r - mcand_r;
      default: booth_sum_s = hi_r;
    endcase
  end

  // Restoring divide step: trial subtract of the divisor from the shifted remainder.
  assign rem_sh_s  = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
  assign diff_s    = rem_sh_s - {1'b0, dvsr_r};
  assign rem_nxt_s = diff_s[WIDTH] ? rem_sh_s[WIDTH-1:0] : diff_s[WIDTH-1:0];

  // Booth treats the multiplier as signed; in unsigned mode a set MSB means the
  // multiplicand shifted by WIDTH must be added back into the upper half.
  assign mul_corr_s = (!sgn_r && bmsb_r) ? {mcand_r[WIDTH-1:0], ZERO_W} : {(2*WIDTH){1'b0}};
  assign mul_prod_s = {hi_r[WIDTH-1:0], lo_r} + mul_corr_s;
  assign mul_exc_s  = sgn_r ? (mul_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod_s[WIDTH-1]}})
                            : (mul_prod_s[2*WIDTH-1:WIDTH] != ZERO_W);

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      hi_r       <= {(WIDTH+2){1'b0}};
      lo_r       <= ZERO_W;
      qm1_r      <= 1'b0;
      mcand_r    <= {(WIDTH+2){1'b0}};
      dvsr_r     <= ZERO_W;
      bmsb_r     <= 1'b0;
      is_mul_r   <= 1'b0;
      sgn_r      <= 1'b1;
      neg_r      <= 1'b0;
      exc_r      <= 1'b0;
      busy       <= 1'b0;
      result_rdy <= 1'b0;
      result     <= ZERO_W;
      exception  <= 1'b0;
    end else if (kill && (state_r != ST_IDLE)) begin
      state_r    <= ST_IDLE;
      busy       <= 1'b0;
      result_rdy <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy       <= 1'b0;
          result_rdy <= 1'b0;
          if (!kill && start_mult) begin
            state_r  <= ST_MUL;
            cnt_r    <= CNT_ZERO;
            hi_r     <= {(WIDTH+2){1'b0}};
            lo_r     <= operand_b;
            qm1_r    <= 1'b0;
            mcand_r  <= start_sgn_s ? {{2{operand_a[WIDTH-1]}}, operand_a} : {2'b00, operand_a};
            bmsb_r   <= operand_b[WIDTH-1];
            is_mul_r <= 1'b1;
            sgn_r    <= start_sgn_s;
          end else if (!kill && start_div) begin
            cnt_r    <= CNT_ZERO;
            hi_r     <= {(WIDTH+2){1'b0}};
            dvsr_r   <= b_mag_s;
            is_mul_r <= 1'b0;
            sgn_r    <= start_sgn_s;
            neg_r    <= a_neg_s ^ b_neg_s;
            if (operand_b == ZERO_W) begin
              state_r <= ST_DONE;
              lo_r    <= ZERO_W;
              exc_r   <= 1'b1;
            end else begin
              state_r <= ST_DIV;
              lo_r    <= a_mag_s;
              exc_r   <= start_ovf_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          busy       <= 1'b1;
          result_rdy <= 1'b0;
          hi_r       <= {booth_sum_s[WIDTH+1], booth_sum_s[WIDTH+1:1]};
          lo_r       <= {booth_sum_s[0], lo_r[WIDTH-1:1]};
          qm1_r      <= lo_r[0];
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DIV: begin
          busy       <= 1'b1;
          result_rdy <= 1'b0;
          hi_r       <= {2'b00, rem_nxt_s};
          lo_r       <= {lo_r[WIDTH-2:0], ~diff_s[WIDTH]};
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_FIX;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_FIX: begin
          busy       <= 1'b1;
          result_rdy <= 1'b0;
          state_r    <= ST_DONE;
          if (neg_r && sgn_r) begin
            lo_r <= ~lo_r + ONE_W;
          end else begin
            lo_r <= lo_r;
          end
        end
        ST_DONE: begin
          busy       <= 1'b1;
          result_rdy <= 1'b1;
          state_r    <= ST_IDLE;
          result     <= is_mul_r ? mul_prod_s[WIDTH-1:0] : lo_r;
          exception  <= is_mul_r ? mul_exc_s : exc_r;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy       <= 1'b0;
          result_rdy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: self-checking bench for multdiv_iter (WIDTH=32).
// A high-level arithmetic model predicts result, exception, ready cycle and busy
// window; a compare process checks every cycle, and directed cases pin literals.
module tb_multdiv_iter;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic          start_mult;
  logic          start_div;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          kill;
  logic          is_uns;
  logic          busy;
  logic          result_rdy;
  logic [W-1:0]  result;
  logic          exception;

  multdiv_iter #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .kill       (kill),
`ifdef MULTDIV_UNSIGNED_EN
    .is_unsigned(is_uns),
`endif
    .busy       (busy),
    .result_rdy (result_rdy),
    .result     (result),
    .exception  (exception)
  );

  typedef struct {
    int           due;
    logic [W-1:0] r;
    bit           e;
  } exp_t;

  exp_t         expq[$];
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;
  int           busy_from = 1;
  int           busy_to = 0;
  int           reset_at = -1;
  logic [W-1:0] exp_r = '0;
  bit           exp_e = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Arithmetic reference: what the unit must return for one operation.
  function automatic void model(input bit m, input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit uns, output logic [W-1:0] r, output bit e);
    longint sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 32'd0;
    e  = 1'b0;
    if (m) begin
      if (uns) begin
        up = ua * ub;
        r  = up[31:0];
        e  = (up[63:32] != 32'd0);
      end else begin
        sp = sa * sb;
        r  = sp[31:0];
        e  = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
      end
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (uns) begin
      r = a / b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = a;
      e = 1'b1;
    end else begin
      sp = sa / sb;
      r  = sp[31:0];
    end
  endfunction

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    bit rdy_due;
    rdy_due = 1'b0;
    if (cyc >= 1) begin
      if (cyc == reset_at) begin
        exp_r = '0;
        exp_e = 1'b0;
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
        rdy_due = 1'b1;
        exp_r   = expq[0].r;
        exp_e   = expq[0].e;
        void'(expq.pop_front());
      end
      check("result_rdy", {63'd0, result_rdy}, {63'd0, rdy_due});
      check("result", {32'd0, result}, {32'd0, exp_r});
      check("exception", {63'd0, exception}, {63'd0, exp_e});
      check("busy", {63'd0, busy}, {63'd0, (cyc >= busy_from && cyc <= busy_to)});
    end
  end

  // Present a start for one cycle (called at a falling edge) and record the prediction.
  task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit uns, output int due);
    logic [W-1:0] r;
    bit e, u;
`ifdef MULTDIV_UNSIGNED_EN
    u = uns;
`else
    u = 1'b0;
`endif
    start_mult = m;
    start_div  = d;
    operand_a  = a;
    operand_b  = b;
    is_uns     = u;
    model(m, a, b, u, r, e);
    if (m)              due = cyc + W + 2;
    else if (b == 32'd0) due = cyc + 2;
    else                due = cyc + W + 3;
    busy_from = cyc + 2;
    busy_to   = due;
    expq.push_back('{due: due, r: r, e: e});
    @(negedge clock);
    start_mult = 1'b0;
    start_div  = 1'b0;
    operand_a  = $urandom;
    operand_b  = $urandom;
    is_uns     = ~u;
  endtask

  // Full operation with literal expectations on the ready cycle; lit_busy<0 skips the busy count.
  task automatic run_op(input string name, input bit m, input bit d, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit uns, input logic [W-1:0] lit_r,
                        input bit lit_e, input int lit_busy);
    int due, nb;
    issue(m, d, a, b, uns, due);
    nb = 0;
    while (cyc < due) begin
      if (busy) nb++;
      @(negedge clock);
    end
    if (busy) nb++;
    check({name, "_rdy"}, {63'd0, result_rdy}, 64'd1);
    check({name, "_res"}, {32'd0, result}, {32'd0, lit_r});
    check({name, "_exc"}, {63'd0, exception}, {63'd0, lit_e});
    if (lit_busy >= 0) check({name, "_busycnt"}, 64'(nb), 64'(lit_busy));
    @(negedge clock);
  endtask

  // Watchdog: the directed sequence is far shorter than this bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int due;
    reset = 1'b1; kill = 1'b0; start_mult = 1'b0; start_div = 1'b0;
    operand_a = '0; operand_b = '0; is_uns = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op("mul_small", 1, 0, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFEB, 0, 33);
    run_op("mul_ovf",   1, 0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0, 1, 33);
    run_op("div_sgn",   0, 1, 32'hFFFF_FF9C, 32'd7, 0, 32'hFFFF_FFF2, 0, 34);
    run_op("div_minm1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1, 34);
    run_op("div_zero",  0, 1, 32'd5, 32'd0, 0, 32'd0, 1, 1);
    run_op("mul_minmin", 1, 0, 32'h8000_0000, 32'h8000_0000, 0, 32'h0, 1, -1);
    run_op("mul_minm1",  1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1, -1);
    run_op("div_neg7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 0, -1);
    run_op("mul_15",     1, 0, 32'd3, 32'd5, 0, 32'd15, 0, -1);

    // Kill in the 10th cycle of a multiply; the previous result must be retained.
    issue(1, 0, 32'd1234, 32'd77, 0, due);
    repeat (9) @(negedge clock);
    kill = 1'b1;
    expq.delete();
    busy_to = cyc;
    @(negedge clock);
    kill = 1'b0;
    check("kill_rdy", {63'd0, result_rdy}, 64'd0);
    check("kill_busy", {63'd0, busy}, 64'd0);
    check("kill_keep", {32'd0, result}, 64'd15);
    @(negedge clock);
    run_op("div_9_3", 0, 1, 32'd9, 32'd3, 0, 32'd3, 0, -1);

    // Start requests while busy are ignored.
    issue(1, 0, 32'd6, 32'd7, 0, due);
    repeat (4) @(negedge clock);
    start_div = 1'b1; operand_a = 32'd100; operand_b = 32'd0;
    @(negedge clock);
    start_div = 1'b0;
    while (cyc < due) @(negedge clock);
    check("ignore_busy_res", {32'd0, result}, 64'd42);
    @(negedge clock);

    // Kill in the DONE cycle: no ready pulse, result unchanged.
    issue(1, 0, 32'd2, 32'd3, 0, due);
    while (cyc < due - 1) @(negedge clock);
    kill = 1'b1;
    expq.delete();
    busy_to = cyc;
    @(negedge clock);
    kill = 1'b0;
    check("kill_done_rdy", {63'd0, result_rdy}, 64'd0);
    check("kill_done_keep", {32'd0, result}, 64'd42);

    // Kill in IDLE drops a start in the same cycle.
    @(negedge clock);
    kill = 1'b1; start_mult = 1'b1; operand_a = 32'd9; operand_b = 32'd9;
    @(negedge clock);
    kill = 1'b0; start_mult = 1'b0;
    repeat (3) @(negedge clock);
    check("kill_idle_busy", {63'd0, busy}, 64'd0);

    // Both starts together: multiply wins; then back-to-back directly after ready.
    run_op("both_start", 1, 1, 32'd6, 32'd2, 0, 32'd12, 0, -1);
    run_op("b2b_mul",    1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd1, 0, -1);
    run_op("b2b_div",    0, 1, 32'd12, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFD, 0, -1);

    // Reset in the middle of a divide clears every output on the next edge.
    issue(0, 1, 32'd100, 32'd3, 0, due);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    expq.delete();
    busy_to  = cyc;
    reset_at = cyc + 1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_res", {32'd0, result}, 64'd0);
    check("rst_mid_exc", {63'd0, exception}, 64'd0);
    check("rst_mid_rdy", {63'd0, result_rdy}, 64'd0);
    @(negedge clock);

`ifdef MULTDIV_UNSIGNED_EN
    run_op("udiv",     0, 1, 32'hFFFF_FFFF, 32'd2, 1, 32'h7FFF_FFFF, 0, 34);
    run_op("umul_ovf", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd1, 1, 33);
    run_op("udiv_min", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 0, -1);
`endif

    // A few model-only operations with pseudo-random operands.
    for (int i = 0; i < 6; i++) begin
      issue(i[0], ~i[0], $urandom, (i == 4) ? 32'd0 : $urandom_range(1000, 1), i[1], due);
      while (cyc < due + 1) @(negedge clock);
    end

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
